// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, lane masks and mask legality helper for dmem_responder.
// Contents: state_t FSM enum, LANE_B0..LANE_B3 / HALF_HI / HALF_LO / WORD_ALL, mask_legal().
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    // Big-endian lanes: mask[3] is byte offset 0 (bits 31:24).
    localparam logic [3:0] LANE_B0  = 4'b1000;
    localparam logic [3:0] LANE_B1  = 4'b0100;
    localparam logic [3:0] LANE_B2  = 4'b0010;
    localparam logic [3:0] LANE_B3  = 4'b0001;
    localparam logic [3:0] HALF_HI  = 4'b1100;
    localparam logic [3:0] HALF_LO  = 4'b0011;
    localparam logic [3:0] WORD_ALL = 4'b1111;

    // Masks a naturally aligned byte/half/word store can produce,
    // plus the empty mask.
    function automatic logic mask_legal(input logic [3:0] m);
        logic ok;
        case (m)
            4'b0000, LANE_B0, LANE_B1, LANE_B2, LANE_B3,
            HALF_HI, HALF_LO, WORD_ALL: ok = 1'b1;
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: data-port request/response bundle.
// master = core side (req, we, addr, wdata, mask out); slave = responder side.
interface dmem_responder_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        mask;
    logic              ready;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata, mask,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, mask,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_bank.sv
// dmem_bank: single-port word RAM with per-byte write enables and registered read.
// Ports: clk, rst (read register only), en, we, addr, wdata, be[3:0], q.
module dmem_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       q
);

    logic [31:0] mem [2**ADDR_W];

    // be[i] covers wdata[8i+7:8i].
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en && !we) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time data-port responder with WAIT_CYCLES wait states.
// Ports: clk, rst (async, active-high), bus (dmem_responder_if.slave).
// Option: DMEM_MASK_CHECK_EN suppresses writes with illegal masks and flags err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        mask_q;
    logic [3:0]        be;
    logic [31:0]       q;
    logic              accept;
    logic              access;

    assign accept = (state == IDLE) && bus.req;
    assign access = (state == BUSY) && (cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.req) state_nx = BUSY;
            BUSY:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Inputs are only looked at on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else if (accept) begin
            cnt     <= WAIT_LD;
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            mask_q  <= bus.mask;
        end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

`ifdef DMEM_MASK_CHECK_EN
    logic bad_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_q <= 1'b0;
        end else if (accept) begin
            bad_q <= bus.we & ~mask_legal(bus.mask);
        end
    end

    assign be      = bad_q ? 4'b0000 : mask_q;
    assign bus.err = (state == RESP) & bad_q;
`else
    assign be      = mask_q;
    assign bus.err = 1'b0;
`endif

    dmem_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .en    (access),
        .we    (we_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .be    (be),
        .q     (q)
    );

    assign bus.ready  = (state == IDLE);
    assign bus.rvalid = (state == RESP);
    // Writes answer with zero data.
    assign bus.rdata  = (state == RESP && !we_q) ? q : 32'h0;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data port, the far end of the load/store alignment logic. Accepts one word-addressed request at a time, carrying a 32-bit store word and a 4-bit big-endian byte-lane mask. Applies byte-lane writes to an internal RAM, or returns the full 32-bit word on reads, after a programmable number of wait states. It answers every accepted request with a single-cycle `rvalid` pulse.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width; RAM depth is 2^ADDR_W words.
- `WAIT_CYCLES`, 1: extra busy cycles before the access edge; legal range 0..15.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  1  request valid.
- `we`  in  1  1 = write, 0 = read.
- `addr`  in  ADDR_W  word address.
- `wdata`  in  32  store word, already lane-positioned.
- `mask`  in  4  byte enables; `mask[3]` = bits 31:24 = byte offset 0 (big-endian).
- `ready`  out  1  request accepted on an edge where `req & ready`.
- `rvalid`  out  1  one-cycle response pulse.
- `rdata`  out  32  read word; valid while `rvalid` = 1.
- `err`  out  1  error flag; valid while `rvalid` = 1.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - `ready` = 1.
  - On `req` at an edge, capture `we`, `addr`, `wdata` and `mask`, load `cnt` = WAIT_CYCLES, and go to BUSY.
- BUSY:
  - `ready` = 0.
  - If `cnt` != 0, decrement `cnt`.
  - If `cnt` = 0, perform the access on this edge and go to RESP.
    - Write: for each i with `mask[i]` = 1, write lane byte `wdata[8i+7:8i]` to `mem[addr]`; other bytes keep their value.
    - Read: register `mem[addr]` into `rdata`.
- RESP:
  - `rvalid` = 1 and `ready` = 0.
  - `rdata` holds the read word, or 32'h0 for writes.
  - Next edge: go to IDLE and clear `rvalid`.
- Reads return the whole word regardless of `mask`; the lane selection and sign extension are done core-side.
- A write with `mask` = 4'b0000 modifies nothing and is still acknowledged.
- Inputs are sampled only on the accept edge. Changes to the inputs while the FSM is in BUSY or RESP are ignored.
- `req` asserted while `ready` = 0 is not accepted, not queued, and has no effect.

## Timing
- Reset values: state = IDLE, `ready` = 1, `rvalid` = 0, `rdata` = 0, `err` = 0, `cnt` = 0. RAM contents are not reset.
- Latency: accept on edge E0, access on edge E(WAIT_CYCLES+1), `rvalid` high for cycle (E(WAIT_CYCLES+1), E(WAIT_CYCLES+2)].
- Throughput: the next accept happens no earlier than edge E(WAIT_CYCLES+3).
- With WAIT_CYCLES = 0, BUSY lasts exactly one cycle, which is the access edge.
- Reset mid-operation:
  - Asserted before the access edge: the pending write is dropped and the RAM is unchanged.
  - Asserted in RESP: the pulse is cut short.
  - Either way, the FSM returns to IDLE asynchronously.
- Read-after-write to the same address on consecutive transactions returns the newly written bytes; no bypass is needed.
- The maximum `addr` (2^ADDR_W − 1) is legal. There is no wrap-around or out-of-range case.

## Configuration
- Macro `DMEM_MASK_CHECK_EN`.
- Defined:
  - Legal write masks are 4'b0000, 1000, 0100, 0010, 0001, 1100, 0011 and 1111.
  - Any other mask with `we` = 1 suppresses the write entirely, still goes through BUSY and RESP, and raises `err` = 1 together with `rvalid`.
  - Reads never raise `err`.
- Undefined: `err` is tied 0 and every mask is applied literally, lane by lane.

## Structure
- Package `dmem_pkg`:
  - FSM state enum.
  - `LANE_B0`..`LANE_B3`, `HALF_HI`, `HALF_LO`, `WORD_ALL` mask constants.
  - Helper function `mask_legal(mask)`.
- Sub-module `dmem_bank`: a synchronous single-port RAM with a 4-bit byte-write enable and a registered read.
- `dmem_responder` holds only the FSM, the wait counter, the capture registers and the error check.

## Test plan
- Write then read, WAIT_CYCLES = 1:
  - Write `addr` 5, `wdata` 32'hDEADBEEF, `mask` 1111; expect `rvalid` 2 edges after accept, `err` = 0.
  - Read `addr` 5; expect `rdata` = 32'hDEADBEEF.
- Byte lane: after the above, write `wdata` 32'h00AA0000 with `mask` 0100, then read `addr` 5; expect `rdata` = 32'hDEAABEEF.
- Half lane: write 32'h00001234 with `mask` 0011 to a word preloaded with 32'hFFFFFFFF; expect read `rdata` = 32'hFFFF1234.
- Illegal mask, macro defined:
  - Write 32'h11111111 with `mask` 1010 to a word holding 32'hDEAABEEF.
  - Expect `err` = 1 with `rvalid`, and a subsequent read returns 32'hDEAABEEF.
  - With the macro undefined, the same write yields 32'h11AA11EF and `err` = 0.
- Backpressure and reset:
  - Hold `req` high through BUSY; expect exactly one response per accept and `ready` = 0 in BUSY and RESP.
  - Assert `rst` during BUSY of a write to `addr` 7; expect `rvalid` never pulses, `ready` = 1 immediately, and `mem[7]` unchanged.
- Zero wait: with WAIT_CYCLES = 0, a read accepted at E0 shows `rvalid` during (E1, E2], and a back-to-back `req` is accepted at E3.
